retire_trace_fifo: RTL and testbench

- Sits directly downstream of the riscv core top level and consumes its per-cycle observation outputs: register write-back (reg_num, reg_data, reg_write_sig) and data-memory access (wr, rd, addr, wr_data, rd_data).
- Converts those outputs into timestamped trace records and buffers them in a dual-push, single-pop FIFO.
- Drains the records over a valid/ready stream toward a debug or UART sink, with drop accounting when the FIFO cannot accept a cycle's events.

---
 rtl/retire_trace_fifo.sv | 136 +++++++++++++
 tb/tb_retire_trace_fifo.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_fifo.sv
// Retire trace capture: turns core write-back and data-memory activity into
// timestamped records in a dual-push, single-pop FWFT FIFO drained over valid/ready.
module retire_trace_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trace_en,
  input  logic                       reg_write_sig,
  input  logic [4:0]                 reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [1:0]                 trace_kind,
  output logic [ADDR_W-1:0]          trace_addr,
  output logic [DATA_W-1:0]          trace_data,
  output logic [TS_W-1:0]            trace_ts,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_count,
  output logic                       err_rdwr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] KIND_REG  = 2'b00;
  localparam logic [1:0] KIND_MEMR = 2'b01;
  localparam logic [1:0] KIND_MEMW = 2'b10;

  typedef struct packed {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } rec_t;

  rec_t              mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [15:0]       drop_q, drop_d;
  logic              err_q, err_d;

  logic              reg_ev, mem_ev, push, pop;
  logic [1:0]        n_ev;
  logic [LVL_W-1:0]  free_slots;
  logic              we0, we1;
  logic [PTR_W-1:0]  idx0, idx1;
  rec_t              rec_reg, rec_mem, rec0, rec_head;

  // Event decode, atomic admission and pointer/occupancy bookkeeping
  always_comb begin
    reg_ev     = trace_en && reg_write_sig && (reg_num != 5'd0);
    mem_ev     = trace_en && (wr || rd);
    n_ev       = {1'b0, reg_ev} + {1'b0, mem_ev};
    free_slots = LVL_W'(DEPTH) - level_q;
    push       = (n_ev != 2'd0) && (free_slots >= LVL_W'(n_ev));
    pop        = (level_q != '0) && trace_ready;

    rec_reg.kind = KIND_REG;
    rec_reg.addr = ADDR_W'(reg_num);
    rec_reg.data = reg_data;
    rec_reg.ts   = ts_q;

    rec_mem.kind = wr ? KIND_MEMW : KIND_MEMR;
    rec_mem.addr = addr;
    rec_mem.data = wr ? wr_data : rd_data;
    rec_mem.ts   = ts_q;

    // REG is the older instruction, so it takes the first slot when both fire
    rec0 = reg_ev ? rec_reg : rec_mem;
    we0  = push && !reset;
    we1  = push && reg_ev && mem_ev && !reset;
    idx0 = tail_q;
    idx1 = tail_q + PTR_W'(1);

    head_d  = pop ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(n_ev) : tail_q;
    level_d = level_q + (push ? LVL_W'(n_ev) : LVL_W'(0)) - LVL_W'(pop);
    ts_d    = ts_q + TS_W'(1);

    drop_d = drop_q;
    if ((n_ev != 2'd0) && !push && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    err_d = err_q || (trace_en && wr && rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      ts_q    <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      ts_q    <= ts_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  // Record storage; contents are don't-care while empty since outputs are gated
  always_ff @(posedge clk) begin
    if (we0) mem_q[idx0] <= rec0;
    if (we1) mem_q[idx1] <= rec_mem;
  end

  always_comb begin
    rec_head = (level_q != '0) ? mem_q[head_q] : '0;
  end

  assign trace_valid = (level_q != '0);
  assign trace_kind  = rec_head.kind;
  assign trace_addr  = rec_head.addr;
  assign trace_data  = rec_head.data;
  assign trace_ts    = rec_head.ts;
  assign level       = level_q;
  assign drop_count  = drop_q;
  assign err_rdwr    = err_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Self-checking bench for retire_trace_fifo against a queue-based trace model.
module tb_retire_trace_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TS_W   = 16;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              trace_en = 1'b0;
  logic              reg_write_sig = 1'b0;
  logic [4:0]        reg_num = '0;
  logic [DATA_W-1:0] reg_data = '0;
  logic              wr = 1'b0;
  logic              rd = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              trace_valid;
  logic              trace_ready = 1'b0;
  logic [1:0]        trace_kind;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [TS_W-1:0]   trace_ts;
  logic [LVL_W-1:0]  level;
  logic [15:0]       drop_count;
  logic              err_rdwr;

  retire_trace_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_kind(trace_kind), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_ts(trace_ts), .level(level), .drop_count(drop_count), .err_rdwr(err_rdwr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } exp_t;

  exp_t m_q[$];
  int   m_drop = 0;
  bit   m_err  = 1'b0;
  int   m_ts   = 0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Apply one clock edge to the model using the current inputs, then let the DUT settle
  task automatic tick();
    bit   reg_ev, mem_ev;
    int   n, lvl;
    exp_t r;
    if (reset) begin
      m_q.delete();
      m_drop = 0;
      m_err  = 1'b0;
      m_ts   = 0;
    end else begin
      reg_ev = trace_en && reg_write_sig && (reg_num != 0);
      mem_ev = trace_en && (wr || rd);
      n = int'(reg_ev) + int'(mem_ev);
      if (trace_en && wr && rd) m_err = 1'b1;
      lvl = m_q.size();
      if (lvl != 0 && trace_ready) void'(m_q.pop_front());
      if (n > 0) begin
        if (DEPTH - lvl >= n) begin
          if (reg_ev) begin
            r.kind = 2'b00; r.addr = ADDR_W'(reg_num); r.data = reg_data; r.ts = TS_W'(m_ts);
            m_q.push_back(r);
          end
          if (mem_ev) begin
            r.kind = wr ? 2'b10 : 2'b01; r.addr = addr;
            r.data = wr ? wr_data : rd_data; r.ts = TS_W'(m_ts);
            m_q.push_back(r);
          end
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    trace_en = 1'b1; reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
    wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    trace_ready = 1'b0;
    do_reset();
    total_cnt++;
    if (trace_valid !== 1'b0 || level !== '0 || drop_count !== 16'd0 || err_rdwr !== 1'b0 ||
        trace_kind !== 2'b00 || trace_addr !== '0 || trace_data !== '0 || trace_ts !== '0)
      $display("FAIL reset_state: valid=%b level=%0d drop=%0d err=%b kind=%b addr=%h data=%h ts=%0d, required all zero",
               trace_valid, level, drop_count, err_rdwr, trace_kind, trace_addr, trace_data, trace_ts);
    else pass_cnt++;
  endtask

  task automatic test_single_store();
    do_reset();
    trace_ready = 1'b1;
    repeat (5) tick();
    wr = 1'b1; addr = 9'h01C; wr_data = 32'hDEADBEEF;
    tick();
    set_idle();
    total_cnt++;
    if (trace_valid !== 1'b1 || trace_kind !== 2'b10 || trace_addr !== 9'h01C ||
        trace_data !== 32'hDEADBEEF || trace_ts !== 16'd5 || level !== LVL_W'(1))
      $display("FAIL single_store: valid=%b kind=%b addr=%h data=%h ts=%0d level=%0d, required 1 10 01c deadbeef 5 1",
               trace_valid, trace_kind, trace_addr, trace_data, trace_ts, level);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (trace_valid !== 1'b0 || level !== '0)
      $display("FAIL single_store_drain: valid=%b level=%0d, required 0 0", trace_valid, level);
    else pass_cnt++;
  endtask

  task automatic test_dual_push();
    logic [TS_W-1:0] ts0;
    do_reset();
    trace_ready = 1'b0;
    repeat (3) tick();
    reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'h11;
    rd = 1'b1; addr = 9'h004; rd_data = 32'h22;
    tick();
    set_idle();
    ts0 = trace_ts;
    total_cnt++;
    if (level !== LVL_W'(2) || trace_kind !== 2'b00 || trace_addr !== 9'd7 ||
        trace_data !== 32'h11 || trace_ts !== 16'd3)
      $display("FAIL dual_first: level=%0d kind=%b addr=%h data=%h ts=%0d, required 2 00 007 00000011 3",
               level, trace_kind, trace_addr, trace_data, trace_ts);
    else pass_cnt++;
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    total_cnt++;
    if (level !== LVL_W'(1) || trace_kind !== 2'b01 || trace_addr !== 9'h004 ||
        trace_data !== 32'h22 || trace_ts !== ts0)
      $display("FAIL dual_second: level=%0d kind=%b addr=%h data=%h ts=%0d, required 1 01 004 00000022 %0d",
               level, trace_kind, trace_addr, trace_data, trace_ts, ts0);
    else pass_cnt++;
  endtask

  task automatic test_x0_write();
    logic [LVL_W-1:0] lvl0;
    logic [15:0]      drop0;
    lvl0 = level; drop0 = drop_count;
    trace_ready = 1'b0;
    reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = 32'hFFFF_0000;
    tick();
    set_idle();
    total_cnt++;
    if (level !== lvl0 || drop_count !== drop0 || level !== LVL_W'(m_q.size()))
      $display("FAIL x0_write: level=%0d drop=%0d, required %0d %0d", level, drop_count, lvl0, drop0);
    else pass_cnt++;
  endtask

  task automatic test_full_drop();
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      wr = 1'b1; addr = ADDR_W'($urandom); wr_data = $urandom;
      tick();
    end
    set_idle();
    total_cnt++;
    if (level !== LVL_W'(DEPTH - 1))
      $display("FAIL fill_level: level=%0d, required %0d", level, DEPTH - 1);
    else pass_cnt++;
    reg_write_sig = 1'b1; reg_num = 5'd3; reg_data = 32'hA5; rd = 1'b1; rd_data = 32'h5A;
    tick();
    set_idle();
    total_cnt++;
    if (level !== LVL_W'(DEPTH - 1) || drop_count !== 16'd1)
      $display("FAIL dual_drop: level=%0d drop=%0d, required %0d 1", level, drop_count, DEPTH - 1);
    else pass_cnt++;
    rd = 1'b1; addr = 9'h1FF; rd_data = 32'hCAFEF00D;
    tick();
    set_idle();
    total_cnt++;
    if (level !== LVL_W'(DEPTH) || drop_count !== 16'd1)
      $display("FAIL last_slot: level=%0d drop=%0d, required %0d 1", level, drop_count, DEPTH);
    else pass_cnt++;
    wr = 1'b1; wr_data = 32'h1;
    tick();
    set_idle();
    total_cnt++;
    if (level !== LVL_W'(DEPTH) || drop_count !== 16'd2)
      $display("FAIL full_drop: level=%0d drop=%0d, required %0d 2", level, drop_count, DEPTH);
    else pass_cnt++;
    trace_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      total_cnt++;
      if (m_q.size() == 0 || trace_valid !== 1'b1 || trace_kind !== m_q[0].kind ||
          trace_addr !== m_q[0].addr || trace_data !== m_q[0].data || trace_ts !== m_q[0].ts)
        $display("FAIL drain_%0d: valid=%b kind=%b addr=%h data=%h ts=%0d, required model head",
                 i, trace_valid, trace_kind, trace_addr, trace_data, trace_ts);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (trace_valid !== 1'b0 || level !== '0)
      $display("FAIL drain_empty: valid=%b level=%0d, required 0 0", trace_valid, level);
    else pass_cnt++;
  endtask

  task automatic test_rdwr_conflict();
    do_reset();
    trace_ready = 1'b0;
    wr = 1'b1; rd = 1'b1; addr = 9'h0AB; wr_data = 32'h1234_5678; rd_data = 32'h8765_4321;
    tick();
    set_idle();
    total_cnt++;
    if (level !== LVL_W'(1) || trace_kind !== 2'b10 || trace_data !== 32'h1234_5678 || err_rdwr !== 1'b1)
      $display("FAIL rdwr_record: level=%0d kind=%b data=%h err=%b, required 1 10 12345678 1",
               level, trace_kind, trace_data, err_rdwr);
    else pass_cnt++;
    trace_ready = 1'b1;
    repeat (10) tick();
    total_cnt++;
    if (err_rdwr !== 1'b1 || level !== '0)
      $display("FAIL rdwr_sticky: err=%b level=%0d, required 1 0", err_rdwr, level);
    else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      trace_en      = ($urandom_range(0, 5) != 0);
      reg_write_sig = $urandom_range(0, 1);
      reg_num       = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom);
      reg_data      = $urandom;
      wr            = ($urandom_range(0, 3) == 0);
      rd            = ($urandom_range(0, 2) == 0);
      addr          = ADDR_W'($urandom);
      wr_data       = $urandom;
      rd_data       = $urandom;
      trace_ready   = ($urandom_range(0, 9) < 4);
      tick();
      total_cnt++;
      if (trace_valid !== (m_q.size() != 0) || level !== LVL_W'(m_q.size()) ||
          drop_count !== 16'(m_drop) || err_rdwr !== m_err ||
          (m_q.size() != 0 && (trace_kind !== m_q[0].kind || trace_addr !== m_q[0].addr ||
                               trace_data !== m_q[0].data || trace_ts !== m_q[0].ts)))
        $display("FAIL random_c%0d: valid=%b level=%0d drop=%0d err=%b kind=%b addr=%h data=%h ts=%0d, required level=%0d drop=%0d err=%b",
                 c, trace_valid, level, drop_count, err_rdwr, trace_kind, trace_addr, trace_data,
                 trace_ts, m_q.size(), m_drop, m_err);
      else pass_cnt++;
    end
    set_idle();
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      reg_write_sig = 1'b1; reg_num = 5'(i + 1); reg_data = $urandom;
      tick();
    end
    set_idle();
    total_cnt++;
    if (level !== LVL_W'(5) || trace_valid !== 1'b1)
      $display("FAIL mid_fill: level=%0d valid=%b, required 5 1", level, trace_valid);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if (trace_valid !== 1'b0 || level !== '0 || drop_count !== 16'd0)
      $display("FAIL mid_reset: valid=%b level=%0d drop=%0d, required 0 0 0", trace_valid, level, drop_count);
    else pass_cnt++;
    wr = 1'b1; addr = 9'h010; wr_data = 32'h77;
    tick();
    set_idle();
    total_cnt++;
    if (trace_valid !== 1'b1 || trace_ts !== 16'd0 || trace_data !== 32'h77)
      $display("FAIL ts_restart: valid=%b ts=%0d data=%h, required 1 0 00000077", trace_valid, trace_ts, trace_data);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_dual_push();
    test_x0_write();
    test_full_drop();
    test_rdwr_conflict();
    test_random();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
